// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : RV32I instruction-fetch stage. Holds the PC, drives the
//               instruction-memory address, and predicts branches through a
//               direct-mapped BTB with 2-bit saturating counters.
// Ports       : clk, reset_n (async, active-low)
//               pc_write       - 1 = advance PC, 0 = hold (load-use stall)
//               redirect_valid - load redirect_pc (word aligned) next cycle
//               redirect_pc    - corrected fetch address
//               update_*       - branch/jump resolution from EX, trains the BTB
//               imem_addr      - instruction-memory address (= pc)
//               imem_rdata     - combinational instruction read data
//               IF_PC, IF_PCplus4, IF_Instr, predict_taken - to IF/ID register
//               if_id_flush    - IF/ID flush, equal to redirect_valid
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  localparam int         IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCplus4,
  output logic [31:0] IF_Instr,
  output logic        predict_taken,
  output logic        if_id_flush
);

  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] c_CTR_MIN   = 2'b00;
  localparam logic [1:0] c_CTR_MAX   = 2'b11;
  localparam logic [1:0] c_CTR_ALLOC = 2'b10;

  // PC and BTB state
  logic [31:0]            r_pc;
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_predict;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;

  // Update-side lookup
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;

  // Low address bits of word-aligned addresses carry no information here.
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^{redirect_pc[1:0], update_pc[1:0]};

  assign w_idx      = r_pc[IDX_W+1:2];
  assign w_tag      = r_pc[31:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_predict  = w_hit && r_ctr[w_idx][1];
  assign w_pc_plus4 = r_pc + 32'd4;   // 0xFFFF_FFFC naturally wraps to 0

  assign w_u_idx = update_pc[IDX_W+1:2];
  assign w_u_tag = update_pc[31:IDX_W+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // Next-PC selection: a redirect wins even over a stall, since the stalled
  // instruction is on the wrong path and is being flushed anyway.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (redirect_valid) begin
      w_next_pc = {redirect_pc[31:2], 2'b00};
    end else if (!pc_write) begin
      w_next_pc = r_pc;
    end else if (w_predict) begin
      w_next_pc = r_target[w_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // BTB training. The fetch lookup above reads the registered contents, so a
  // same-index update only becomes visible to fetch on the following cycle.
  // Stalls do not gate training: EX resolution is independent of IF holding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (update_valid) begin
      if (w_u_hit) begin
        if (update_taken) begin
          r_target[w_u_idx] <= update_target;
          if (r_ctr[w_u_idx] != c_CTR_MAX) begin
            r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
          end
        end else if (r_ctr[w_u_idx] != c_CTR_MIN) begin
          r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
        end
      end else if (update_taken) begin
        // Taken miss allocates, evicting any conflicting tag at this index.
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= update_target;
        r_ctr[w_u_idx]    <= c_CTR_ALLOC;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign IF_PC         = r_pc;
  assign IF_PCplus4    = w_pc_plus4;
  assign IF_Instr      = imem_rdata;
  assign predict_taken = w_predict;
  assign if_id_flush   = redirect_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCplus4;
  logic [31:0] IF_Instr;
  logic        predict_taken;
  logic        if_id_flush;

  int pass_cnt;
  int total_cnt;

  if_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_target  (update_target),
    .update_taken   (update_taken),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .IF_PC          (IF_PC),
    .IF_PCplus4     (IF_PCplus4),
    .IF_Instr       (IF_Instr),
    .predict_taken  (predict_taken),
    .if_id_flush    (if_id_flush)
  );

  // Combinational instruction memory: an address-derived pattern.
  assign imem_rdata = {imem_addr[15:0], ~imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic btb_update(input logic [31:0] p, input logic [31:0] t, input logic tk);
    update_valid  = 1'b1;
    update_pc     = p;
    update_target = t;
    update_taken  = tk;
    tick();
    update_valid  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset_n = 1'b0;
    pc_write = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
    #12;
    total_cnt++; if (IF_PC !== 32'h0) $display("FAIL rst_pc got=%h exp=%h", IF_PC, 32'h0); else pass_cnt++;
    total_cnt++; if (IF_PCplus4 !== 32'h4) $display("FAIL rst_pc4 got=%h exp=%h", IF_PCplus4, 32'h4); else pass_cnt++;
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL rst_pred got=%b exp=0", predict_taken); else pass_cnt++;
    total_cnt++; if (if_id_flush !== 1'b0) $display("FAIL rst_flush got=%b exp=0", if_id_flush); else pass_cnt++;
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = 32'(4 * i);
      total_cnt++; if (IF_PC !== e) $display("FAIL seq_pc[%0d] got=%h exp=%h", i, IF_PC, e); else pass_cnt++;
      total_cnt++; if (imem_addr !== e) $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, e); else pass_cnt++;
      total_cnt++; if (IF_Instr !== {e[15:0], ~e[15:0]}) $display("FAIL seq_instr[%0d] got=%h exp=%h", i, IF_Instr, {e[15:0], ~e[15:0]}); else pass_cnt++;
      total_cnt++; if (predict_taken !== 1'b0) $display("FAIL seq_pred[%0d] got=%b exp=0", i, predict_taken); else pass_cnt++;
    end
  endtask

  task automatic test_allocate();
    // Redirect to 0x10 and allocate 0x10 -> 0x40 in the same cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    update_valid = 1'b1; update_pc = 32'h10; update_target = 32'h40; update_taken = 1'b1;
    #1;
    total_cnt++; if (if_id_flush !== 1'b1) $display("FAIL alloc_flush got=%b exp=1", if_id_flush); else pass_cnt++;
    tick();
    redirect_valid = 1'b0; update_valid = 1'b0;
    total_cnt++; if (IF_PC !== 32'h10) $display("FAIL alloc_pc got=%h exp=%h", IF_PC, 32'h10); else pass_cnt++;
    total_cnt++; if (predict_taken !== 1'b1) $display("FAIL alloc_pred got=%b exp=1", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h40) $display("FAIL alloc_tgt got=%h exp=%h", IF_PC, 32'h40); else pass_cnt++;
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL alloc_pred40 got=%b exp=0", predict_taken); else pass_cnt++;
  endtask

  task automatic test_counter();
    btb_update(32'h10, 32'h0, 1'b0);            // ctr 10 -> 01
    redirect_to(32'h10);
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL ctr01_pred got=%b exp=0", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h14) $display("FAIL ctr01_next got=%h exp=%h", IF_PC, 32'h14); else pass_cnt++;
    // 01 -> 10 -> 11 -> 11 (saturate), then one not-taken -> 10.
    for (int i = 0; i < 3; i++) btb_update(32'h10, 32'h80, 1'b1);
    btb_update(32'h10, 32'h0, 1'b0);
    redirect_to(32'h10);
    total_cnt++; if (predict_taken !== 1'b1) $display("FAIL ctr_sat_pred got=%b exp=1", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h80) $display("FAIL ctr_newtgt got=%h exp=%h", IF_PC, 32'h80); else pass_cnt++;
  endtask

  task automatic test_stall_redirect();
    logic [31:0] held;
    held = IF_PC;
    pc_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (IF_PC !== held) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, IF_PC, held); else pass_cnt++;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    total_cnt++; if (if_id_flush !== 1'b1) $display("FAIL redir_flush got=%b exp=1", if_id_flush); else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total_cnt++; if (IF_PC !== 32'h100) $display("FAIL redir_pc got=%h exp=%h", IF_PC, 32'h100); else pass_cnt++;
    total_cnt++; if (if_id_flush !== 1'b0) $display("FAIL redir_flush_clr got=%b exp=0", if_id_flush); else pass_cnt++;
    // Stall on a predicted-taken PC while EX trains the same entry (10 -> 01).
    pc_write = 1'b1;
    redirect_to(32'h10);
    pc_write = 1'b0;
    btb_update(32'h10, 32'h0, 1'b0);
    total_cnt++; if (IF_PC !== 32'h10) $display("FAIL stall_pred_hold got=%h exp=%h", IF_PC, 32'h10); else pass_cnt++;
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL stall_upd_pred got=%b exp=0", predict_taken); else pass_cnt++;
    pc_write = 1'b1;
    tick();
    total_cnt++; if (IF_PC !== 32'h14) $display("FAIL stall_release got=%h exp=%h", IF_PC, 32'h14); else pass_cnt++;
  endtask

  task automatic test_alias();
    btb_update(32'h10, 32'h40, 1'b1);           // hit: ctr 01 -> 10, target 0x40
    btb_update(32'h90, 32'h300, 1'b0);          // same idx, not-taken miss: no write
    redirect_to(32'h10);
    total_cnt++; if (predict_taken !== 1'b1) $display("FAIL ntmiss_keep got=%b exp=1", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h40) $display("FAIL ntmiss_tgt got=%h exp=%h", IF_PC, 32'h40); else pass_cnt++;
    btb_update(32'h50, 32'h200, 1'b1);          // taken miss evicts 0x10
    redirect_to(32'h10);
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL alias_old_pred got=%b exp=0", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h14) $display("FAIL alias_old_next got=%h exp=%h", IF_PC, 32'h14); else pass_cnt++;
    redirect_to(32'h50);
    total_cnt++; if (predict_taken !== 1'b1) $display("FAIL alias_new_pred got=%b exp=1", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h200) $display("FAIL alias_new_tgt got=%h exp=%h", IF_PC, 32'h200); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    redirect_to(32'h50);
    update_valid = 1'b1; update_pc = 32'h50; update_target = 32'h0; update_taken = 1'b0;
    #1;
    total_cnt++; if (predict_taken !== 1'b1) $display("FAIL same_pre_pred got=%b exp=1", predict_taken); else pass_cnt++;
    tick();
    update_valid = 1'b0;
    total_cnt++; if (IF_PC !== 32'h200) $display("FAIL same_pre_tgt got=%h exp=%h", IF_PC, 32'h200); else pass_cnt++;
    redirect_to(32'h50);
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL same_post_pred got=%b exp=0", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h54) $display("FAIL same_post_next got=%h exp=%h", IF_PC, 32'h54); else pass_cnt++;
  endtask

  task automatic test_wrap_reset();
    redirect_to(32'hFFFF_FFFC);
    total_cnt++; if (IF_PC !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got=%h exp=%h", IF_PC, 32'hFFFF_FFFC); else pass_cnt++;
    total_cnt++; if (IF_PCplus4 !== 32'h0) $display("FAIL wrap_pc4 got=%h exp=%h", IF_PCplus4, 32'h0); else pass_cnt++;
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL wrap_pred got=%b exp=0", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h0) $display("FAIL wrap_next got=%h exp=%h", IF_PC, 32'h0); else pass_cnt++;
    tick();
    // Pending redirect, then asynchronous reset in the middle of the cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (IF_PC !== 32'h0) $display("FAIL async_rst_pc got=%h exp=%h", IF_PC, 32'h0); else pass_cnt++;
    total_cnt++; if (IF_PCplus4 !== 32'h4) $display("FAIL async_rst_pc4 got=%h exp=%h", IF_PCplus4, 32'h4); else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    reset_n = 1'b1;
    total_cnt++; if (IF_PC !== 32'h0) $display("FAIL rst_redir_lost got=%h exp=%h", IF_PC, 32'h0); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h4) $display("FAIL post_rst_adv got=%h exp=%h", IF_PC, 32'h4); else pass_cnt++;
    redirect_to(32'h50);
    total_cnt++; if (predict_taken !== 1'b0) $display("FAIL btb_cleared got=%b exp=0", predict_taken); else pass_cnt++;
    tick();
    total_cnt++; if (IF_PC !== 32'h54) $display("FAIL btb_cleared_next got=%h exp=%h", IF_PC, 32'h54); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_allocate();
    test_counter();
    test_stall_redirect();
    test_alias();
    test_same_cycle();
    test_wrap_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
